// File: rtl/diff_io_pkg.sv
// rtl/diff_io_pkg.sv - shared defaults and pair-state type for the differential input block
package diff_io_pkg;

  localparam int   CNT_W_DEFAULT         = 8;
  localparam logic DEFAULT_LEVEL_DEFAULT = 1'b0;

  typedef enum logic {
    PAIR_VALID   = 1'b0,
    PAIR_INVALID = 1'b1
  } pair_state_e;

  function automatic pair_state_e pair_state(input logic p, input logic n);
    return (p != n) ? PAIR_VALID : PAIR_INVALID;
  endfunction

endpackage

// File: rtl/diff_ibuf.sv
// rtl/diff_ibuf.sv - combinational differential decode; swap point for a vendor IBUFDS
module diff_ibuf
  import diff_io_pkg::*;
(
  input  logic p,
  input  logic n,
  input  logic hold,
  output logic o,
  output logic valid
);

  always_comb begin
    valid = (pair_state(p, n) == PAIR_VALID);
    o     = valid ? p : hold;
  end

endmodule

// File: rtl/diff_io_top.sv
// rtl/diff_io_top.sv - differential pad decode with level hold, error flag and counters
// Optional error counter enabled by DIFF_IO_ERR_CNT_EN; otherwise err_cnt is tied to 0.
module diff_io_top
  import diff_io_pkg::*;
#(
  parameter int   CNT_W         = CNT_W_DEFAULT,
  parameter logic DEFAULT_LEVEL = DEFAULT_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             diff_i_p,
  input  logic             diff_i_n,
  output logic             led,
  output logic             pair_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] rise_cnt
);

  logic             pair_valid;
  logic             hold_q, hold_d;
  logic             pair_err_q, pair_err_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic             rise_inc;

  diff_ibuf u_ibuf (
    .p     (diff_i_p),
    .n     (diff_i_n),
    .hold  (hold_q),
    .o     (led),
    .valid (pair_valid)
  );

  always_comb begin
    hold_d     = hold_q;
    pair_err_d = !pair_valid;
    rise_inc   = pair_valid && diff_i_p && !hold_q;
    rise_cnt_d = rise_cnt_q + {{(CNT_W-1){1'b0}}, rise_inc};
    if (pair_valid) begin
      hold_d = diff_i_p;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q     <= DEFAULT_LEVEL;
      pair_err_q <= 1'b0;
      rise_cnt_q <= '0;
    end else begin
      hold_q     <= hold_d;
      pair_err_q <= pair_err_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

`ifdef DIFF_IO_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturate rather than wrap so a long fault never reads as a small count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (!pair_valid && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign pair_err = pair_err_q;
  assign rise_cnt = rise_cnt_q;

endmodule

// File: tb/tb_diff_io_top.sv
// tb/tb_diff_io_top.sv - directed self-checking bench for diff_io_top (CNT_W=4)
module tb_diff_io_top;

  localparam int   CNT_W = 4;
  localparam logic DEF   = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             diff_i_p;
  logic             diff_i_n;
  logic             led;
  logic             pair_err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] rise_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef DIFF_IO_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  diff_io_top #(.CNT_W(CNT_W), .DEFAULT_LEVEL(DEF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .diff_i_p (diff_i_p),
    .diff_i_n (diff_i_n),
    .led      (led),
    .pair_err (pair_err),
    .err_cnt  (err_cnt),
    .rise_cnt (rise_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] err_exp(input int n);
    int capped;
    capped = (n > 15) ? 15 : n;
    return ERR_EN ? 16'(capped) : 16'd0;
  endfunction

  task automatic pads(input logic p, input logic n);
    diff_i_p = p;
    diff_i_n = n;
    #1;
  endtask

  initial begin
    logic sig;

    // reset with a valid pair p=0,n=1
    rst_n = 1'b0;
    pads(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_led", led, 1'b0);
    chk("rst_pair_err", pair_err, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_rise_cnt", rise_cnt, 0);
    pads(1'b1, 1'b1);
    chk("rst_led_invalid", led, DEF);
    @(negedge clk);
    chk("rst_pair_err_invalid", pair_err, 1'b0);
    chk("rst_err_cnt_invalid", err_cnt, 0);

    // release and toggle 10 cycles starting from 0: rises at odd cycles
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sig = i[0];
      pads(sig, ~sig);
      chk("tog_led", led, sig);
      @(negedge clk);
      chk("tog_pair_err", pair_err, 1'b0);
      chk("tog_err_cnt", err_cnt, 0);
    end
    chk("tog_rise_cnt", rise_cnt, 5);

    // invalid hold: one valid 1, then three cycles of 11
    pads(1'b1, 1'b0);
    chk("inv_led_pre", led, 1'b1);
    @(negedge clk);
    chk("inv_pair_err_pre", pair_err, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      pads(1'b1, 1'b1);
      chk("inv_led_hold", led, 1'b1);
      @(negedge clk);
      chk("inv_pair_err", pair_err, 1'b1);
      chk("inv_err_cnt", err_cnt, err_exp(k));
    end
    chk("inv_rise_cnt", rise_cnt, 5);
    pads(1'b1, 1'b0);
    @(negedge clk);
    chk("inv_pair_err_post", pair_err, 1'b0);
    chk("inv_err_cnt_post", err_cnt, err_exp(3));

    // reset mid-run with invalid pair; hold_q is 1 going in
    rst_n = 1'b0;
    pads(1'b0, 1'b0);
    chk("mid_led_pre", led, 1'b1);
    @(negedge clk);
    chk("mid_led", led, DEF);
    chk("mid_pair_err", pair_err, 1'b0);
    chk("mid_err_cnt", err_cnt, 0);
    chk("mid_rise_cnt", rise_cnt, 0);
    rst_n = 1'b1;

    // saturation: 20 cycles of 00
    for (int k = 1; k <= 20; k++) begin
      pads(1'b0, 1'b0);
      chk("sat_led", led, DEF);
      @(negedge clk);
      chk("sat_pair_err", pair_err, 1'b1);
      chk("sat_err_cnt", err_cnt, err_exp(k));
    end
    chk("sat_rise_cnt", rise_cnt, 0);

    // rise_cnt wraps: 17 rises with CNT_W=4 leaves 1
    for (int i = 0; i < 34; i++) begin
      sig = ~i[0];
      pads(sig, ~sig);
      chk("wrap_led", led, sig);
      @(negedge clk);
    end
    chk("wrap_rise_cnt", rise_cnt, 1);
    chk("wrap_err_cnt", err_cnt, err_exp(20));
    chk("wrap_pair_err", pair_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/diff_io_top.md
# diff_io_top

Top-level differential-input feature block. It receives one differential pad pair (`diff_i_p`/`diff_i_n`), decodes it as a true-differential input buffer would, and drives the decoded level to `led` with zero latency. A clocked monitor alongside the data path holds the last valid level, flags invalid (non-complementary) pad states, and optionally counts them. It sits directly behind the board pads as the design's top module.

## Interface
- `CNT_W`, default 8: width of `err_cnt` and `rise_cnt`; legal range is 2 to 16.
- `DEFAULT_LEVEL`, default 1'b0: value of the held level after reset.
- `clk` in, 1: single system clock; all state updates on its rising edge.
- `rst_n` in, 1: reset, synchronous and active-low.
- `diff_i_p` in, 1: positive leg of the differential input.
- `diff_i_n` in, 1: negative leg of the differential input.
- `led` out, 1: decoded differential level.
- `pair_err` out, 1: registered flag; pads were equal at the last sampled edge.
- `err_cnt` out, CNT_W: saturating count of sampled invalid cycles.
- `rise_cnt` out, CNT_W: wrapping count of sampled valid 0→1 transitions of the decoded level.

## Operation
- Pair state:
  - Valid when `diff_i_p != diff_i_n`.
  - Invalid when the two legs are equal (00 or 11).
- `led` is combinational:
  - When the pair is valid, `led = diff_i_p`.
  - When the pair is invalid, `led = hold_q`.
- `hold_q` register:
  - On each clock edge with a valid pair, `hold_q <= diff_i_p`.
  - On an invalid pair, `hold_q` keeps its value.
- `pair_err <= (diff_i_p == diff_i_n)`, updated on every edge.
- `err_cnt` increments on each edge that samples an invalid pair. It saturates at all-ones.
- `rise_cnt` increments when a valid sample is 1 and `hold_q` was 0. It wraps modulo 2^CNT_W.
- No X propagation from the pads is handled; the pads are treated as clean 0/1 values.

## Timing
- `pads→led`: combinational, 0 cycles, for valid pairs. At any rising edge, `led` equals the currently applied `diff_i_p`, before any registered update.
- `pair_err`, `err_cnt`, `rise_cnt`, `hold_q`: 1-cycle latency from the sampled edge.
- Reset values while `rst_n == 0` at an edge:
  - `hold_q = DEFAULT_LEVEL`
  - `pair_err = 0`
  - `err_cnt = 0`
  - `rise_cnt = 0`
- During reset, `led` still follows valid pads combinationally. With an invalid pair during reset, `led` shows `hold_q`, which equals `DEFAULT_LEVEL` after the first reset edge.
- Reset asserted mid-operation clears the counters on that edge; pad activity on the same edge is ignored.
- An invalid pair lasting N edges adds N to `err_cnt`, capped at 2^CNT_W−1. `hold_q` is frozen for those N edges.

## Configuration
- Macro: `DIFF_IO_ERR_CNT_EN`.
- Defined: `err_cnt` is implemented as specified.
- Undefined: the counter logic is compiled out and `err_cnt` is tied to 0. `pair_err` and all other behaviour are unchanged.

## Structure
- Shared package `diff_io_pkg` holds:
  - `localparam` defaults for `CNT_W` and `DEFAULT_LEVEL`.
  - Typedef `pair_state_e` with values `PAIR_VALID` and `PAIR_INVALID`.
- One sub-module, `diff_ibuf`:
  - Contains the combinational decode: inputs `p`, `n`, `hold`; outputs `o`, `valid`.
  - Is the single place to swap in a vendor IBUFDS primitive.
- The counters and registers live in `diff_io_top`.

## Test plan
- Reset hold: `rst_n = 0` for 1 cycle with p=0, n=1, then release and toggle `sig` every clock (p=sig, n=~sig) for 10 cycles. Required: `led == sig` at every rising edge, `pair_err = 0`, `err_cnt = 0`.
- Rise count: after reset, toggle for 10 cycles starting from 0. Required: `rise_cnt = 5` one cycle after the last edge.
- Invalid hold: drive p=1, n=0 for 1 cycle, then p=n=1 for 3 cycles. Required:
  - `led` stays 1.
  - `pair_err = 1` for 3 cycles, delayed by 1.
  - `err_cnt = 3`.
  - `hold_q` stays 1.
- Saturation: with `CNT_W = 4`, drive p=n=0 for 20 cycles. Required: `err_cnt = 15` and it does not wrap.
- Reset mid-run: after `err_cnt = 3`, assert `rst_n = 0` for 1 edge with an invalid pair. Required: all counters are 0 and `led = DEFAULT_LEVEL`.
- Macro off: build without `DIFF_IO_ERR_CNT_EN` and repeat the invalid-hold scenario. Required: `err_cnt = 0`, `pair_err` still asserts for 3 cycles.
